uart_rx_param: RTL

Parametrised UART receiver that generalises the fixed 8N1/9600 receiver. It supports configurable clock/baud, 5–9 data bits, optional parity, 1 or 2 stop bits, 16x oversampling with 3-sample majority vote, and error/break detection. Received bytes go into a small output FIFO with a valid/read handshake. It sits between the board serial pin and the game-control logic, and lets the consumer stall without losing bytes.

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the parametrised UART receiver: FIFO read handshake and
// per-frame status pulses.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 RD_EN;
  logic [DATA_BITS-1:0] DATA;
  logic                 VALID;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 OVERRUN;
  logic                 BREAK_DET;

  modport master (
    input  RD_EN,
    output DATA, VALID, PARITY_ERR, FRAME_ERR, OVERRUN, BREAK_DET
  );

  modport slave (
    output RD_EN,
    input  DATA, VALID, PARITY_ERR, FRAME_ERR, OVERRUN, BREAK_DET
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling with 2-of-3 majority vote, optional parity,
// 1/2 stop bits, break detection and a small output FIFO.
module uart_rx_param #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            UART_RX,
  uart_rx_param_if.master bus
);
  localparam int unsigned TICK_DIV = CLK_HZ / (16 * BAUD);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

  state_e               state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [3:0]           sample_cnt_q;
  logic                 s7_q, s8_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, stop_idx_q, stop_bad_q;
  logic                 par_err_q, frame_err_q, overrun_q, break_q;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;

  logic tick, bit_done, maj, fall, data_zero, par_calc, par_bad, last_stop;
  logic brk, frame, decide, good, full, pop, push, ovr;

  assign tick      = (state_q != StIdle) && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign bit_done  = tick && (sample_cnt_q == 4'd9);
  assign maj       = (s7_q & s8_q) | (s7_q & rx_s2_q) | (s8_q & rx_s2_q);
  assign fall      = rx_prev_q & ~rx_s2_q;
  assign data_zero = (shift_q == '0);
  assign par_calc  = (PARITY == 1) ? ~^shift_q : ^shift_q;
  assign par_bad   = (PARITY != 0) && (par_calc != par_bit_q);
  assign last_stop = (STOP_BITS == 1) || stop_idx_q;

  // A break is an all-zero frame whose first stop bit is also low.
  assign brk    = (state_q == StStop) && bit_done && !maj && data_zero && !par_bit_q &&
                  !stop_idx_q;
  assign frame  = !maj || stop_bad_q;
  assign decide = (state_q == StStop) && bit_done && last_stop && !brk;
  assign good   = decide && !frame && !par_bad;
  assign full   = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop    = bus.RD_EN && (count_q != '0);
  assign push   = good && (!full || pop);
  assign ovr    = good && full && !pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_idx_q   <= 1'b0;
      stop_bad_q   <= 1'b0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      rx_s1_q     <= UART_RX;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      frame_err_q <= decide && frame;
      par_err_q   <= decide && !frame && par_bad;
      overrun_q   <= ovr;
      break_q     <= brk;

      if (state_q == StIdle || tick) tick_cnt_q <= '0;
      else                           tick_cnt_q <= tick_cnt_q + TW'(1);

      if (tick) begin
        sample_cnt_q <= sample_cnt_q + 4'd1;
        if (sample_cnt_q == 4'd7) s7_q <= rx_s2_q;
        if (sample_cnt_q == 4'd8) s8_q <= rx_s2_q;
      end

      unique case (state_q)
        StIdle: begin
          sample_cnt_q <= '0;
          if (fall) state_q <= StStart;
        end
        StStart: if (bit_done) begin
          if (maj) begin
            state_q <= StIdle;
          end else begin
            state_q    <= StData;
            bit_cnt_q  <= '0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            stop_bad_q <= 1'b0;
          end
        end
        StData: if (bit_done) begin
          shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) state_q <= (PARITY != 0) ? StParity : StStop;
          else                                bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        StParity: if (bit_done) begin
          par_bit_q <= maj;
          state_q   <= StStop;
        end
        StStop: if (bit_done) begin
          // Final decision returns to idle mid-bit so the next start edge is caught.
          if (brk)            state_q <= StWaitHigh;
          else if (last_stop) state_q <= StIdle;
          else begin
            stop_bad_q <= !maj;
            stop_idx_q <= 1'b1;
          end
        end
        StWaitHigh: if (rx_s2_q) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign bus.VALID      = (count_q != '0);
  assign bus.DATA       = bus.VALID ? mem_q[rd_ptr_q] : '0;
  assign bus.PARITY_ERR = par_err_q;
  assign bus.FRAME_ERR  = frame_err_q;
  assign bus.OVERRUN    = overrun_q;
  assign bus.BREAK_DET  = break_q;
endmodule
